fetch_prefetch_queue: RTL

Parametrised successor of the single-entry IF stage. It decouples PC generation from decode through a DEPTH-entry instruction queue, and talks to instruction memory over a pipelined valid/ready request port with in-order responses of arbitrary latency. Redirects (jump/branch/jalr) from ID/EX flush the queue and discard in-flight stale responses. Sits between the PC/redirect logic and the IF/ID consumer; replaces the IF/ID register.

---
 rtl/fetch_prefetch_queue_pkg.sv | 19 +
 rtl/fetch_prefetch_queue_sync_fifo.sv | 66 ++++++
 rtl/fetch_prefetch_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// rtl/fetch_prefetch_queue_pkg.sv - shared types and defaults for the fetch prefetch queue
package fetch_prefetch_queue_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

  localparam logic [ILEN_DEFAULT-1:0] NOP_ZERO = '0;

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// rtl/fetch_prefetch_queue_sync_fifo.sv - synchronous FIFO with flush, used for PC tags and the instruction queue
module fetch_prefetch_queue_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push lands in, so push-on-full is legal with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - IF stage with DEPTH-entry prefetch queue, credit-limited requests and redirect drain
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              ILEN     = ILEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  output logic            ImemReqValid,
  output logic [XLEN-1:0] ImemReqAddr,
  input  logic            ImemReqReady,
  input  logic            ImemRespValid,
  input  logic [ILEN-1:0] ImemRespData,
  output logic            IF_ID_Valid,
  output logic [ILEN-1:0] IF_ID_Instruction,
  output logic [XLEN-1:0] IF_ID_PC,
  input  logic            ID_Ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            req_fire, resp_keep, head_pop;
  logic [CW:0]     credit_used;

  logic [XLEN-1:0]      tag_pc;
  logic                 tag_full, tag_empty;
  logic [CW-1:0]        tag_count;
  logic [XLEN+ILEN-1:0] iq_head;
  logic                 iq_full, iq_empty;
  logic [CW-1:0]        iq_count;

  // Outstanding includes stale in-flight requests, so the queue can never overflow after a drain.
  assign credit_used  = {1'b0, outstanding_q} + {1'b0, iq_count};
  assign ImemReqValid = !Reset && !Redirect && !tag_full && (credit_used < (CW+1)'(DEPTH));
  assign ImemReqAddr  = fetch_pc_q;
  assign req_fire     = ImemReqValid && ImemReqReady;
  assign resp_keep    = ImemRespValid && !Redirect && (state_q == FETCH);
  assign head_pop     = IF_ID_Valid && ID_Ready && !Redirect;

  assign IF_ID_Valid       = !iq_empty;
  assign IF_ID_PC          = IF_ID_Valid ? iq_head[XLEN+ILEN-1:ILEN] : '0;
  assign IF_ID_Instruction = IF_ID_Valid ? iq_head[ILEN-1:0] : ILEN'(NOP_ZERO);

  fetch_prefetch_queue_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .CLK       (CLK),
    .Reset     (Reset),
    .flush     (Redirect),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (resp_keep),
    .pop_data  (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  fetch_prefetch_queue_sync_fifo #(.WIDTH(XLEN+ILEN), .DEPTH(DEPTH)) u_instr_queue (
    .CLK       (CLK),
    .Reset     (Reset),
    .flush     (Redirect),
    .push      (resp_keep),
    .push_data ({tag_pc, ImemRespData}),
    .pop       (head_pop),
    .pop_data  (iq_head),
    .full      (iq_full),
    .empty     (iq_empty),
    .count     (iq_count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(ImemRespValid);
    drop_cnt_d    = drop_cnt_q;
    state_d       = state_q;
    if (Redirect) begin
      fetch_pc_d = {RedirectPC[XLEN-1:2], 2'b00};
      drop_cnt_d = outstanding_q - CW'(ImemRespValid);
      state_d    = (drop_cnt_d != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      case (state_q)
        FETCH: state_d = FETCH;
        DRAIN: begin
          if (ImemRespValid) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
            if (drop_cnt_q == CW'(1)) state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Live tags are a subset of outstanding requests; a response with nothing outstanding is a memory bug.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      assert (!(ImemRespValid && outstanding_q == '0));
      assert (tag_count <= outstanding_q);
      assert (!(resp_keep && tag_empty));
      assert (!(resp_keep && iq_full && !head_pop));
    end
  end

endmodule
